// File: rtl/lsu_pkg.sv
// Shared encodings and the access legality check for the load/store unit.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ERR       = 3'd1,
        ST_LD_WAIT   = 3'd2,
        ST_LD_CAP    = 3'd3,
        ST_RMW_WAIT  = 3'd4,
        ST_RMW_MERGE = 3'd5,
        ST_WR        = 3'd6
    } lsu_state_e;

    // High when the size is illegal or the address is not naturally aligned for it.
    function automatic logic access_fault(input logic [1:0] size, input logic [1:0] addr_lo);
        logic fault;
        case (size)
            SZ_B:    fault = 1'b0;
            SZ_H:    fault = addr_lo[0];
            SZ_W:    fault = (addr_lo != 2'b00);
            default: fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extraction/extension for loads and lane merge for sub-word stores.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed lane of the read word and extend it to 32 bits.
    always_comb begin
        byte_s = 8'h00;
        case (addr_lo)
            2'd0:    byte_s = word[7:0];
            2'd1:    byte_s = word[15:8];
            2'd2:    byte_s = word[23:16];
            2'd3:    byte_s = word[31:24];
            default: byte_s = 8'h00;
        endcase
        half_s = addr_lo[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_B:    load_data = {{24{~is_unsigned & byte_s[7]}}, byte_s};
            SZ_H:    load_data = {{16{~is_unsigned & half_s[15]}}, half_s};
            default: load_data = word;
        endcase
    end

    // Overwrite only the addressed lane, keeping the rest of the old word.
    always_comb begin
        merge_data = word;
        case (size)
            SZ_B:    merge_data[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            SZ_H:    merge_data[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            SZ_W:    merge_data = wdata;
            default: merge_data = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator for a word-addressed registered-read memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);

    lsu_state_e        state_r, state_s;
    logic [1:0]        size_r;
    logic [1:0]        addr_lo_r;
    logic              uns_r;
    logic [31:0]       wdata_r;
    logic              accept_s;
    logic              ready_s, rsp_valid_s, rsp_err_s, mem_we_s;
    logic [31:0]       rsp_rdata_s, mem_wd_s;
    logic [ADDR_W-1:0] mem_a_s;
    logic [31:0]       load_data_s, merge_data_s;
    logic              unused_addr_s;

    // Upper address bits are deliberately dropped so accesses wrap.
    assign unused_addr_s = ^req_addr[31:ADDR_W+2];
    assign accept_s      = req_valid & req_ready;

    lsu_align u_align (
        .size        (size_r),
        .addr_lo     (addr_lo_r),
        .is_unsigned (uns_r),
        .word        (mem_rd),
        .wdata       (wdata_r),
        .load_data   (load_data_s),
        .merge_data  (merge_data_s)
    );

    // Capture request fields on accept; the bus is ignored afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            size_r    <= SZ_B;
            addr_lo_r <= 2'b00;
            uns_r     <= 1'b0;
            wdata_r   <= 32'h0000_0000;
        end else if (accept_s) begin
            size_r    <= req_size;
            addr_lo_r <= req_addr[1:0];
            uns_r     <= req_unsigned;
            wdata_r   <= req_wdata;
        end else begin
            size_r    <= size_r;
            addr_lo_r <= addr_lo_r;
            uns_r     <= uns_r;
            wdata_r   <= wdata_r;
        end
    end

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0000_0000;
            rsp_err   <= 1'b0;
            mem_we    <= 1'b0;
            mem_a     <= '0;
            mem_wd    <= 32'h0000_0000;
        end else begin
            state_r   <= state_s;
            req_ready <= ready_s;
            rsp_valid <= rsp_valid_s;
            rsp_rdata <= rsp_rdata_s;
            rsp_err   <= rsp_err_s;
            mem_we    <= mem_we_s;
            mem_a     <= mem_a_s;
            mem_wd    <= mem_wd_s;
        end
    end

    // Next-state and next-output decode; mem_we defaults low so it is a single-cycle pulse.
    always_comb begin
        state_s     = state_r;
        ready_s     = req_ready;
        rsp_valid_s = 1'b0;
        rsp_rdata_s = rsp_rdata;
        rsp_err_s   = 1'b0;
        mem_we_s    = 1'b0;
        mem_a_s     = mem_a;
        mem_wd_s    = mem_wd;
        case (state_r)
            ST_IDLE: begin
                ready_s = 1'b1;
                if (accept_s) begin
                    ready_s = 1'b0;
                    mem_a_s = req_addr[ADDR_W+1:2];
                    if (access_fault(req_size, req_addr[1:0])) begin
                        state_s = ST_ERR;
                    end else if (req_we && (req_size == SZ_W)) begin
                        mem_we_s = 1'b1;
                        mem_wd_s = req_wdata;
                        state_s  = ST_WR;
                    end else if (req_we) begin
                        state_s = ST_RMW_WAIT;
                    end else begin
                        state_s = ST_LD_WAIT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ERR: begin
                rsp_valid_s = 1'b1;
                rsp_err_s   = 1'b1;
                rsp_rdata_s = 32'h0000_0000;
                ready_s     = 1'b1;
                state_s     = ST_IDLE;
            end
            ST_LD_WAIT:  state_s = ST_LD_CAP;
            ST_LD_CAP: begin
                rsp_valid_s = 1'b1;
                rsp_rdata_s = load_data_s;
                ready_s     = 1'b1;
                state_s     = ST_IDLE;
            end
            ST_RMW_WAIT: state_s = ST_RMW_MERGE;
            ST_RMW_MERGE: begin
                mem_we_s = 1'b1;
                mem_wd_s = merge_data_s;
                state_s  = ST_WR;
            end
            ST_WR: begin
                rsp_valid_s = 1'b1;
                rsp_rdata_s = 32'h0000_0000;
                ready_s     = 1'b1;
                state_s     = ST_IDLE;
            end
            default: begin
                ready_s = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: byte-level reference memory model plus directed and random requests.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_we;
    logic [4:0]  mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:31];
    logic [7:0]  ref_bytes [0:127];
    int          tests_run = 0;
    int          tests_failed = 0;
    int          we_cnt = 0;

    load_store_unit #(.ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
        .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_a] <= mem_wd;
        mem_rd <= mem[mem_a];
    end

    always @(negedge clk) if (mem_we) we_cnt = we_cnt + 1;

    function automatic logic [31:0] ref_word(input int w);
        return {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
    endfunction

    function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd3) return 1'b1;
        if (size == 2'd1) return addr[0];
        if (size == 2'd2) return addr[1:0] != 2'd0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns, input logic [31:0] addr);
        int b;
        logic [15:0] h;
        b = int'(addr[6:0]);
        h = {ref_bytes[(b + 1) % 128], ref_bytes[b]};
        if (size == 2'd0) return uns ? {24'd0, ref_bytes[b]} : {{24{ref_bytes[b][7]}}, ref_bytes[b]};
        if (size == 2'd1) return uns ? {16'd0, h} : {{16{h[15]}}, h};
        return ref_word(b / 4);
    endfunction

    task automatic model_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        int b;
        int n;
        b = int'(addr[6:0]);
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        for (int i = 0; i < n; i++) ref_bytes[b + i] = wdata[8*i +: 8];
    endtask

    task automatic preload();
        logic [31:0] w;
        for (int i = 0; i < 32; i++) begin
            w = (i == 3) ? 32'h8081F2A4 : $urandom;
            mem[i] = w;
            for (int k = 0; k < 4; k++) ref_bytes[4*i + k] = w[8*k +: 8];
        end
    endtask

    task automatic do_req(input string name, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_we;
        int          lat;
        int          n;
        logic        got;
        exp_err   = model_err(size, addr);
        exp_rdata = (exp_err || we) ? 32'h0 : model_load(size, uns, addr);
        exp_lat   = exp_err ? 1 : (!we ? 2 : (size == 2'd2 ? 1 : 3));
        exp_we    = (we && !exp_err) ? 1 : 0;
        @(negedge clk);
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (!req_ready) begin
            tests_failed++;
            $display("FAIL %s accept: req_ready stayed %b, required 1", name, req_ready);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        we_cnt = 0;
        @(negedge clk);
        req_valid = 1'b0;
        tests_run++;
        if (req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s ready_drop: got %b, required 0", name, req_ready);
        end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 8) begin
            @(negedge clk);
            lat++;
            if (rsp_valid === 1'b1) got = 1'b1;
        end
        #1;
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("FAIL %s timeout: no rsp_valid within %0d cycles", name, lat);
            return;
        end
        tests_run++;
        if (lat != exp_lat) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d, required %0d", name, lat, exp_lat);
        end
        tests_run++;
        if (rsp_err !== exp_err || rsp_rdata !== exp_rdata) begin
            tests_failed++;
            $display("FAIL %s response: got err=%b rdata=%h, required err=%b rdata=%h",
                     name, rsp_err, rsp_rdata, exp_err, exp_rdata);
        end
        tests_run++;
        if (we_cnt != exp_we || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s we_pulses/ready: got %0d/%b, required %0d/1", name, we_cnt, req_ready, exp_we);
        end
        if (exp_we == 1) model_store(size, addr, wdata);
        tests_run++;
        if (mem[addr[6:2]] !== ref_word(int'(addr[6:2]))) begin
            tests_failed++;
            $display("FAIL %s mem_word: got %h, required %h", name, mem[addr[6:2]], ref_word(int'(addr[6:2])));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_a, mem_wd} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got ready=%b valid=%b rdata=%h err=%b we=%b a=%h wd=%h, required all 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_a, mem_wd);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b, required 1", req_ready);
        end
    endtask

    task automatic test_loads();
        preload();
        do_req("ld_word",     1'b0, 2'd2, 1'b0, 32'h0C, 32'h0);
        do_req("ld_sbyte",    1'b0, 2'd0, 1'b0, 32'h0C, 32'h0);
        do_req("ld_ubyte",    1'b0, 2'd0, 1'b1, 32'h0F, 32'h0);
        do_req("ld_shalf",    1'b0, 2'd1, 1'b0, 32'h0E, 32'h0);
        do_req("ld_uhalf",    1'b0, 2'd1, 1'b1, 32'h0E, 32'h0);
        tests_run++;
        if (rsp_rdata !== 32'h00008081) begin
            tests_failed++;
            $display("FAIL ld_uhalf_const: got %h, required 00008081", rsp_rdata);
        end
    endtask

    task automatic test_stores();
        preload();
        do_req("st_byte", 1'b1, 2'd0, 1'b0, 32'h0D, 32'h00000055);
        tests_run++;
        if (mem[3] !== 32'h808155A4) begin
            tests_failed++;
            $display("FAIL st_byte_const: got %h, required 808155a4", mem[3]);
        end
        do_req("st_half", 1'b1, 2'd1, 1'b0, 32'h0C, 32'h00001234);
        tests_run++;
        if (mem[3] !== 32'h80811234) begin
            tests_failed++;
            $display("FAIL st_half_const: got %h, required 80811234", mem[3]);
        end
    endtask

    task automatic test_errors();
        preload();
        do_req("err_st_word", 1'b1, 2'd2, 1'b0, 32'h0E, 32'hCAFEF00D);
        do_req("err_ld_half", 1'b0, 2'd1, 1'b0, 32'h0D, 32'h0);
        do_req("err_size",    1'b0, 2'd3, 1'b0, 32'h0C, 32'h0);
    endtask

    task automatic test_reset_rmw();
        int seen;
        int n;
        preload();
        @(negedge clk);
        req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h0D; req_wdata = 32'h55;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_a, mem_wd} !== '0) begin
            tests_failed++;
            $display("FAIL rmw_reset_outputs: got ready=%b valid=%b we=%b a=%h wd=%h, required all 0",
                     req_ready, rsp_valid, mem_we, mem_a, mem_wd);
        end
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen++;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen++;
        end
        tests_run++;
        if (seen != 0 || mem[3] !== 32'h8081F2A4) begin
            tests_failed++;
            $display("FAIL rmw_reset_nowrite: got rsp=%0d word3=%h, required 0 and 8081f2a4", seen, mem[3]);
        end
        do_req("rmw_reset_reload", 1'b0, 2'd2, 1'b0, 32'h0C, 32'h0);
    endtask

    task automatic test_back_to_back();
        int          pulses;
        int          accepts;
        logic        switch_next;
        logic        drop_next;
        logic [31:0] last;
        logic [31:0] exp;
        preload();
        model_store(2'd2, 32'h80, 32'hDEADBEEF);
        exp = model_load(2'd2, 1'b0, 32'h00);
        pulses = 0; accepts = 0; switch_next = 1'b0; drop_next = 1'b0; last = 32'h0;
        @(negedge clk);
        req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h80; req_wdata = 32'hDEADBEEF;
        req_valid = 1'b1;
        if (req_ready) begin
            accepts = 1;
            switch_next = 1'b1;
        end
        repeat (20) begin
            @(negedge clk);
            if (drop_next) begin
                req_valid = 1'b0;
                drop_next = 1'b0;
            end
            if (switch_next) begin
                req_we = 1'b0; req_addr = 32'h00; req_wdata = 32'h0;
                switch_next = 1'b0;
            end
            if (rsp_valid === 1'b1) begin
                pulses++;
                last = rsp_rdata;
            end
            if (req_valid && req_ready) begin
                accepts++;
                if (accepts == 1) switch_next = 1'b1;
                else drop_next = 1'b1;
            end
        end
        req_valid = 1'b0;
        tests_run++;
        if (pulses != 2 || last !== exp || last !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL back_to_back: got pulses=%0d rdata=%h, required 2 and %h", pulses, last, exp);
        end
    endtask

    task automatic test_random();
        logic [1:0]  size;
        logic [31:0] addr;
        preload();
        for (int i = 0; i < 40; i++) begin
            size = 2'($urandom_range(0, 3));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (size == 2'd1) addr[0] = 1'b0;
                if (size == 2'd2) addr[1:0] = 2'b00;
            end
            do_req("random", 1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)), addr, $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_errors();
        test_reset_rmw();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
